// File: rtl/adc_capture_pkg.sv
// Shared types for the triggered ADC capture controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam logic [1:0] TRIG_IMM  = 2'd0;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;
    localparam logic [1:0] TRIG_EXT  = 2'd3;

endpackage

// File: rtl/adc_trig_detect.sv
// Trigger detector: immediate, ch1 signed threshold crossing, or external level.
// Latency: combinational trigger on the qualifying sample; previous sample registered.
// Backpressure: none; evaluates only on adc-valid cycles.
module adc_trig_detect
    import adc_capture_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic                     ext_trig,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic signed [DATA_W-1:0] ch1,
    input  logic                     valid,
    output logic                     trig
);

    logic signed [DATA_W-1:0] prev_ch1;
    logic                     prev_vld;
    logic                     cur_ge;
    logic                     prev_ge;
    logic                     hit;

    // An arm discards history so a crossing can never straddle two captures.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_ch1 <= '0;
            prev_vld <= 1'b0;
        end else if (clear) begin
            prev_vld <= 1'b0;
        end else if (valid) begin
            prev_ch1 <= ch1;
            prev_vld <= 1'b1;
        end
    end

    assign cur_ge  = (ch1 >= threshold);
    assign prev_ge = (prev_ch1 >= threshold);

    always_comb begin
        hit = 1'b0;
        case (mode)
            TRIG_IMM:  hit = 1'b1;
            TRIG_RISE: hit = prev_vld && !prev_ge && cur_ge;
            TRIG_FALL: hit = prev_vld && prev_ge && !cur_ge;
            TRIG_EXT:  hit = ext_trig;
            default:   hit = 1'b0;
        endcase
    end

    assign trig = enable && valid && hit;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered capture controller feeding the capture FIFO write port from the ADC interface.
// Latency: one cycle from accepted sample slot to fifo_wr_en/fifo_din.
// Backpressure: prog_full drops the slot (still counted) and sets sticky overflow.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int LEN_W   = 20,
    parameter int DECIM_W = 8,
    parameter int DATA_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                arm,
    input  logic                abort,
    input  logic [1:0]          trig_mode,
    input  logic                ext_trig,
    input  logic [DATA_W-1:0]   threshold,
    input  logic [LEN_W-1:0]    capture_len,
    input  logic [DECIM_W-1:0]  decim,
    input  logic [DATA_W-1:0]   adc_data_1,
    input  logic [DATA_W-1:0]   adc_data_2,
    input  logic                adc_valid,
    input  logic                fifo_prog_full,
    output logic [2*DATA_W-1:0] fifo_din,
    output logic                fifo_wr_en,
    output logic                armed,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [LEN_W-1:0]    sample_count
);

    cap_state_t         state;
    logic [1:0]         mode_q;
    logic [DATA_W-1:0]  thr_q;
    logic [LEN_W-1:0]   len_q;
    logic [DECIM_W-1:0] decim_q;
    logic [DECIM_W-1:0] dec_cnt;

    logic               arm_ok;
    logic               trig;
    logic               advance;
    logic               take_slot;
    logic               last_slot;
    logic [LEN_W-1:0]   cnt_nxt;
    logic [DECIM_W-1:0] dec_nxt;

    assign arm_ok = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));

    adc_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (arm_ok),
        .enable    (state == ST_ARMED),
        .mode      (mode_q),
        .ext_trig  (ext_trig),
        .threshold (thr_q),
        .ch1       (adc_data_1),
        .valid     (adc_valid),
        .trig      (trig)
    );

    // The triggering sample is slot 0, so it shares the slot path with capture.
    assign advance   = adc_valid && ((state == ST_CAPTURE) || (trig && (len_q != '0)));
    assign take_slot = advance && (dec_cnt == '0);
    assign cnt_nxt   = sample_count + LEN_W'(1);
    assign last_slot = take_slot && (cnt_nxt == len_q);
    assign dec_nxt   = (dec_cnt == decim_q) ? '0 : dec_cnt + DECIM_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            mode_q       <= TRIG_IMM;
            thr_q        <= '0;
            len_q        <= '0;
            decim_q      <= '0;
            dec_cnt      <= '0;
            sample_count <= '0;
            fifo_din     <= '0;
            fifo_wr_en   <= 1'b0;
            armed        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            if (abort) begin
                state    <= ST_IDLE;
                armed    <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b0;
                overflow <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            mode_q       <= trig_mode;
                            thr_q        <= threshold;
                            len_q        <= capture_len;
                            decim_q      <= decim;
                            dec_cnt      <= '0;
                            sample_count <= '0;
                            overflow     <= 1'b0;
                            state        <= ST_ARMED;
                            armed        <= 1'b1;
                            busy         <= 1'b1;
                            done         <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (trig) begin
                            armed <= 1'b0;
                            if ((len_q == '0) || last_slot) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_CAPTURE;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (last_slot) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        armed <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase

                if (advance) begin
                    dec_cnt <= dec_nxt;
                end
                if (take_slot) begin
                    sample_count <= cnt_nxt;
                    if (fifo_prog_full) begin
                        overflow <= 1'b1;
                    end else begin
                        fifo_wr_en <= 1'b1;
                        fifo_din   <= {adc_data_1, adc_data_2};
                    end
                end
            end
        end
    end

endmodule
